// File: rtl/rr_interval_timer.sv
// Peak-to-peak interval timer: counts sample ticks between accepted peaks and
// offers the result on a valid/ready output register, in one-shot or continuous mode.
module rr_interval_timer #(
    parameter int unsigned CNT_W     = 8,
    parameter int unsigned MIN_TICKS = 5,
    parameter int unsigned MAX_TICKS = 75
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             tick,
    input  logic             peak,
    input  logic             mode,
    output logic [CNT_W-1:0] interval,
    output logic             interval_valid,
    input  logic             interval_ready,
    output logic             peak_rejected,
    output logic             timeout,
    output logic             overrun,
    output logic             busy
);

    localparam logic [CNT_W-1:0] MIN_CNT  = CNT_W'(MIN_TICKS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_TICKS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COUNT = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mode_q, mode_d;
    logic [CNT_W-1:0] interval_q, interval_d;
    logic             valid_q, valid_d;
    logic             rej_q, rej_d;
    logic             timeout_q, timeout_d;
    logic             overrun_q, overrun_d;
    logic             busy_q, busy_d;

    // Next-state and output-register logic
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mode_d     = mode_q;
        interval_d = interval_q;
        valid_d    = valid_q;
        rej_d      = 1'b0;
        timeout_d  = 1'b0;
        overrun_d  = 1'b0;

        if (valid_q && interval_ready) begin
            valid_d = 1'b0;
        end

        unique case (state_q)
            S_IDLE: begin
                if (en && peak) begin
                    state_d = S_COUNT;
                    cnt_d   = '0;
                    mode_d  = mode;
                end
            end
            S_COUNT: begin
                if (!en) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (tick && (cnt_q == LAST_CNT)) begin
                    // Timeout wins over a same-cycle peak
                    timeout_d = 1'b1;
                    state_d   = S_IDLE;
                    cnt_d     = '0;
                end else if (peak && (cnt_q >= MIN_CNT)) begin
                    if (!mode_q) begin
                        interval_d = cnt_q;
                        valid_d    = 1'b1;
                        state_d    = S_HOLD;
                    end else begin
                        cnt_d = '0;
                        if (!valid_q || interval_ready) begin
                            interval_d = cnt_q;
                            valid_d    = 1'b1;
                        end else begin
                            overrun_d = 1'b1;
                        end
                    end
                end else begin
                    rej_d = peak;
                    if (tick) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_HOLD: begin
                if (interval_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            mode_q     <= 1'b0;
            interval_q <= '0;
            valid_q    <= 1'b0;
            rej_q      <= 1'b0;
            timeout_q  <= 1'b0;
            overrun_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mode_q     <= mode_d;
            interval_q <= interval_d;
            valid_q    <= valid_d;
            rej_q      <= rej_d;
            timeout_q  <= timeout_d;
            overrun_q  <= overrun_d;
            busy_q     <= busy_d;
        end
    end

    assign interval       = interval_q;
    assign interval_valid = valid_q;
    assign peak_rejected  = rej_q;
    assign timeout        = timeout_q;
    assign overrun        = overrun_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_rr_interval_timer.sv
// Bench for rr_interval_timer: directed scenarios plus random traffic, all
// outputs compared every cycle against a behavioural model of the timer.
module tb_rr_interval_timer;

    localparam int unsigned CNT_W     = 8;
    localparam int unsigned MIN_TICKS = 5;
    localparam int unsigned MAX_TICKS = 75;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             en = 1'b1;
    logic             tick = 1'b0;
    logic             peak = 1'b0;
    logic             mode = 1'b0;
    logic             interval_ready = 1'b0;
    logic [CNT_W-1:0] interval;
    logic             interval_valid;
    logic             peak_rejected;
    logic             timeout;
    logic             overrun;
    logic             busy;

    int n_checks = 0;
    int n_fail   = 0;

    rr_interval_timer #(
        .CNT_W    (CNT_W),
        .MIN_TICKS(MIN_TICKS),
        .MAX_TICKS(MAX_TICKS)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .tick          (tick),
        .peak          (peak),
        .mode          (mode),
        .interval      (interval),
        .interval_valid(interval_valid),
        .interval_ready(interval_ready),
        .peak_rejected (peak_rejected),
        .timeout       (timeout),
        .overrun       (overrun),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // Behavioural model: measuring / holding flags, tick count, output slot
    bit m_measuring, m_holding, m_cont;
    int m_ticks;
    int m_out;
    bit m_out_full;
    bit m_rej, m_to, m_ov;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        bit taken;
        m_rej = 0; m_to = 0; m_ov = 0;
        if (rst) begin
            m_measuring = 0; m_holding = 0; m_cont = 0;
            m_ticks = 0; m_out = 0; m_out_full = 0;
            return;
        end
        taken = m_out_full && interval_ready;
        if (taken) m_out_full = 0;
        if (m_holding) begin
            if (interval_ready) m_holding = 0;
        end else if (!m_measuring) begin
            if (en && peak) begin
                m_measuring = 1; m_ticks = 0; m_cont = mode;
            end
        end else if (!en) begin
            m_measuring = 0; m_ticks = 0;
        end else if (tick && m_ticks + 1 >= int'(MAX_TICKS)) begin
            m_to = 1; m_measuring = 0; m_ticks = 0;
        end else if (peak && m_ticks >= int'(MIN_TICKS)) begin
            if (!m_cont) begin
                m_out = m_ticks; m_out_full = 1;
                m_measuring = 0; m_holding = 1;
            end else begin
                if (m_out_full) m_ov = 1;
                else begin m_out = m_ticks; m_out_full = 1; end
                m_ticks = 0;
            end
        end else begin
            m_rej = peak;
            if (tick) m_ticks++;
        end
    endtask

    task automatic compare_model();
        check("interval", 32'(interval), 32'(m_out));
        check("valid", 32'(interval_valid), 32'(m_out_full));
        check("peak_rejected", 32'(peak_rejected), 32'(m_rej));
        check("timeout", 32'(timeout), 32'(m_to));
        check("overrun", 32'(overrun), 32'(m_ov));
        check("busy", 32'(busy), 32'(m_measuring || m_holding));
    endtask

    task automatic cyc(input bit t, input bit p);
        tick = t;
        peak = p;
        model_step();
        @(posedge clk);
        #1;
        compare_model();
        tick = 0;
        peak = 0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            cyc(1'b1, 1'b0);
            cyc(1'b0, 1'b0);
        end
    endtask

    task automatic accept();
        interval_ready = 1'b1;
        cyc(1'b0, 1'b0);
        interval_ready = 1'b0;
    endtask

    initial begin
        // Reset
        rst = 1'b1;
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        rst = 1'b0;
        check("rst_interval", 32'(interval), 32'd0);
        check("rst_valid", 32'(interval_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);

        // One-shot basic
        mode = 1'b0;
        cyc(1'b0, 1'b1);
        check("os_busy", 32'(busy), 32'd1);
        ticks(20);
        cyc(1'b0, 1'b1);
        check("os_interval", 32'(interval), 32'd20);
        check("os_valid", 32'(interval_valid), 32'd1);
        ticks(3);
        cyc(1'b0, 1'b1);
        check("os_hold_interval", 32'(interval), 32'd20);
        accept();
        check("os_valid_after", 32'(interval_valid), 32'd0);
        check("os_busy_after", 32'(busy), 32'd0);

        // Refractory
        cyc(1'b0, 1'b1);
        ticks(3);
        cyc(1'b0, 1'b1);
        check("ref_rejected", 32'(peak_rejected), 32'd1);
        cyc(1'b0, 1'b0);
        check("ref_pulse_end", 32'(peak_rejected), 32'd0);
        ticks(17);
        cyc(1'b0, 1'b1);
        check("ref_interval", 32'(interval), 32'd20);
        accept();

        // Timeout
        cyc(1'b0, 1'b1);
        ticks(74);
        check("to_early", 32'(timeout), 32'd0);
        cyc(1'b1, 1'b1);
        check("to_pulse", 32'(timeout), 32'd1);
        check("to_valid", 32'(interval_valid), 32'd0);
        check("to_busy", 32'(busy), 32'd0);
        cyc(1'b0, 1'b0);
        check("to_pulse_end", 32'(timeout), 32'd0);

        // Simultaneous tick and peak
        cyc(1'b0, 1'b1);
        ticks(10);
        cyc(1'b1, 1'b1);
        check("sim_interval", 32'(interval), 32'd10);
        accept();

        // Continuous with overrun; mode drop mid-measurement is ignored
        mode = 1'b1;
        cyc(1'b0, 1'b1);
        mode = 1'b0;
        ticks(12);
        cyc(1'b0, 1'b1);
        check("cont_first", 32'(interval), 32'd12);
        check("cont_busy", 32'(busy), 32'd1);
        ticks(9);
        cyc(1'b0, 1'b1);
        check("cont_overrun", 32'(overrun), 32'd1);
        check("cont_kept", 32'(interval), 32'd12);
        accept();
        check("cont_drained", 32'(interval_valid), 32'd0);
        ticks(12);
        cyc(1'b0, 1'b1);
        check("cont_next", 32'(interval), 32'd12);
        check("cont_next_valid", 32'(interval_valid), 32'd1);

        // Reset mid-COUNT with valid pending
        ticks(4);
        rst = 1'b1;
        cyc(1'b0, 1'b0);
        rst = 1'b0;
        check("rabort_valid", 32'(interval_valid), 32'd0);
        check("rabort_interval", 32'(interval), 32'd0);
        check("rabort_busy", 32'(busy), 32'd0);

        // Enable abort keeps the pending output
        mode = 1'b1;
        cyc(1'b0, 1'b1);
        ticks(6);
        cyc(1'b0, 1'b1);
        en = 1'b0;
        cyc(1'b0, 1'b0);
        en = 1'b1;
        check("eabort_busy", 32'(busy), 32'd0);
        check("eabort_valid", 32'(interval_valid), 32'd1);
        check("eabort_interval", 32'(interval), 32'd6);
        accept();
        check("eabort_taken", 32'(interval_valid), 32'd0);

        // Random traffic
        for (int i = 0; i < 6000; i++) begin
            rst            = ($urandom_range(0, 499) == 0);
            en             = ($urandom_range(0, 99) != 0);
            mode           = 1'($urandom_range(0, 1));
            interval_ready = ($urandom_range(0, 9) < 2);
            cyc(($urandom_range(0, 9) < 3), ($urandom_range(0, 99) < 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
